// File: rtl/alu_pipe.sv
// Two-stage pipelined Y-86 execute ALU (add/sub/and/xor) with registered ZF/SF/OF
// and valid/ready handshakes. Define ALU_EXT_OPS_EN to add op 4 (or) and op 5 (shl).
module alu_pipe #(
  parameter int W   = 64,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           set_cc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   result,
  output logic           out_err,
  output logic           zf,
  output logic           sf,
  output logic           of
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_XOR = OPW'(3);
`ifdef ALU_EXT_OPS_EN
  localparam logic [OPW-1:0] OP_OR  = OPW'(4);
  localparam logic [OPW-1:0] OP_SHL = OPW'(5);
  localparam int SHW = $clog2(W);
`endif

  // vld_pipe[1]: S1 occupied, vld_pipe[2]: S2 occupied (drives out_valid)
  logic [2:1]     vld_pipe;
  logic [OPW-1:0] op1;
  logic [W-1:0]   a1, b1;
  logic           cc1;
  logic           adv2, accept;
  logic [W-1:0]   res;
  logic           ill, ovf;

  assign adv2      = vld_pipe[1] & (~vld_pipe[2] | out_ready);
  assign in_ready  = ~vld_pipe[1] | adv2;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_pipe[2];

  always_comb begin
    res = '0;
    ill = 1'b0;
    ovf = 1'b0;
    case (op1)
      OP_ADD: begin
        res = b1 + a1;
        ovf = (a1[W-1] == b1[W-1]) & (res[W-1] != b1[W-1]);
      end
      OP_SUB: begin
        res = b1 - a1;
        ovf = (a1[W-1] != b1[W-1]) & (res[W-1] != b1[W-1]);
      end
      OP_AND: res = b1 & a1;
      OP_XOR: res = b1 ^ a1;
`ifdef ALU_EXT_OPS_EN
      OP_OR:  res = b1 | a1;
      OP_SHL: res = b1 << a1[SHW-1:0];
`endif
      default: ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      op1      <= '0;
      a1       <= '0;
      b1       <= '0;
      cc1      <= 1'b0;
      result   <= '0;
      out_err  <= 1'b0;
      zf       <= 1'b1;
      sf       <= 1'b0;
      of       <= 1'b0;
    end else begin
      if (accept) begin
        vld_pipe[1] <= 1'b1;
        op1         <= op;
        a1          <= a;
        b1          <= b;
        cc1         <= set_cc;
      end else if (adv2) begin
        vld_pipe[1] <= 1'b0;
      end

      if (adv2) begin
        vld_pipe[2] <= 1'b1;
        result      <= res;
        out_err     <= ill;
        // illegal ops never touch the flags, even with set_cc
        if (cc1 & ~ill) begin
          zf <= (res == '0);
          sf <= res[W-1];
          of <= ovf;
        end
      end else if (out_ready) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

endmodule
